// File: rtl/neuron_mac_if.sv
// Handshake bundle between the neuron MAC, its input feeder and the
// downstream activation stage. The MAC sits on the slave side.
interface neuron_mac_if #(
   parameter int DATA_W = 8
);

   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] x_in;
   logic signed [DATA_W-1:0] w_in;
   logic signed [DATA_W-1:0] bias;
   logic                     z_valid;
   logic                     z_ready;
   logic signed [DATA_W-1:0] z_value;
   logic                     sat;

   modport master (
      output in_valid, x_in, w_in, bias, z_ready,
      input  in_ready, z_valid, z_value, sat
   );

   modport slave (
      input  in_valid, x_in, w_in, bias, z_ready,
      output in_ready, z_valid, z_value, sat
   );

endinterface

// File: rtl/neuron_mac.sv
// Single-neuron multiply-accumulate: takes N_INPUTS (x, w) beats plus a bias
// sampled on the first beat and produces a saturated Q.4 weighted sum.
module neuron_mac #(
   parameter int N_INPUTS = 2,
   parameter int DATA_W   = 8
) (
   input  logic           clk,
   input  logic           rst,
   neuron_mac_if.slave    bus
);

   localparam int PROD_W = 2 * DATA_W;
   localparam int CNT_W  = $clog2(N_INPUTS + 1);
   localparam int ACC_W  = PROD_W + CNT_W;

   localparam logic [CNT_W-1:0] LAST_IN_ACC = CNT_W'(N_INPUTS - 1);

   // Output range limits expressed at accumulator width for the clip compare.
   localparam logic signed [ACC_W-1:0] Z_MAX =
      {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] Z_MIN =
      {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      OUT
   } state_t;

   state_t state;
   state_t state_next;

   logic                     armed;
   logic                     ready;
   logic                     accept;
   logic                     load_z;

   logic signed [PROD_W-1:0] product;
   logic signed [ACC_W-1:0]  product_ext;
   logic signed [ACC_W-1:0]  bias_ext;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  acc_next;
   logic signed [ACC_W-1:0]  shifted;
   logic [CNT_W-1:0]         cnt;
   logic [CNT_W-1:0]         cnt_next;

   logic signed [DATA_W-1:0] z_reg;
   logic signed [DATA_W-1:0] z_next;
   logic                     sat_reg;
   logic                     sat_next;

   assign accept = bus.in_valid && ready;
   assign load_z = accept && (state_next == OUT);

   // State register; armed keeps in_ready low until the first edge after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         armed <= 1'b0;
      end else begin
         state <= state_next;
         armed <= 1'b1;
      end
   end

   // Next-state logic: collect N_INPUTS beats, then hold the result until consumed.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = (N_INPUTS == 1) ? OUT : ACC;
            end
         end
         ACC: begin
            if (accept && (cnt == LAST_IN_ACC)) begin
               state_next = OUT;
            end
         end
         OUT: begin
            if (bus.z_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Output decode: ready while collecting, valid while holding a result.
   always_comb begin
      ready          = armed && (state != OUT);
      bus.in_ready   = ready;
      bus.z_valid    = (state == OUT);
      bus.z_value    = z_reg;
      bus.sat        = sat_reg;
   end

   // Accumulator update: bias is shifted up 4 bits to line up with the
   // 8 fractional bits of the full-width product.
   always_comb begin
      product     = bus.x_in * bus.w_in;
      product_ext = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
      bias_ext    = {{(ACC_W-DATA_W-4){bus.bias[DATA_W-1]}}, bus.bias, 4'b0000};
      acc_next    = acc;
      cnt_next    = cnt;
      if (accept && (state == IDLE)) begin
         acc_next = bias_ext + product_ext;
         cnt_next = CNT_W'(1);
      end else if (accept && (state == ACC)) begin
         acc_next = acc + product_ext;
         cnt_next = cnt + CNT_W'(1);
      end
   end

   // Drop back to 4 fractional bits with floor rounding, then clip to DATA_W.
   always_comb begin
      shifted  = acc_next >>> 4;
      z_next   = shifted[DATA_W-1:0];
      sat_next = 1'b0;
      if (shifted > Z_MAX) begin
         z_next   = Z_MAX[DATA_W-1:0];
         sat_next = 1'b1;
      end else if (shifted < Z_MIN) begin
         z_next   = Z_MIN[DATA_W-1:0];
         sat_next = 1'b1;
      end
   end

   // Datapath registers; the result is captured only on the final beat so it
   // stays frozen for as long as the downstream stage stalls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc     <= '0;
         cnt     <= '0;
         z_reg   <= '0;
         sat_reg <= 1'b0;
      end else begin
         acc <= acc_next;
         cnt <= cnt_next;
         if (load_z) begin
            z_reg   <= z_next;
            sat_reg <= sat_next;
         end
      end
   end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac with N_INPUTS=2, DATA_W=8.
module tb_neuron_mac;

   localparam int DATA_W = 8;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   neuron_mac_if #(.DATA_W(DATA_W)) bus ();

   neuron_mac #(
      .N_INPUTS(2),
      .DATA_W  (DATA_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                              input logic [DATA_W-1:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Presents one beat starting at a falling edge and holds it across one rising edge.
   task automatic applyStimulus(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] w,
                                input logic [DATA_W-1:0] b);
      bus.in_valid = 1'b1;
      bus.x_in     = x;
      bus.w_in     = w;
      bus.bias     = b;
      @(negedge clk);
   endtask

   // Two-beat evaluation with z_ready held high; bias on beat 2 must be ignored.
   task automatic runEval(input string tag,
                          input logic [DATA_W-1:0] x0, input logic [DATA_W-1:0] w0,
                          input logic [DATA_W-1:0] x1, input logic [DATA_W-1:0] w1,
                          input logic [DATA_W-1:0] b,
                          input logic [DATA_W-1:0] exp_z, input logic exp_sat);
      checkOutput({tag, ".ready_idle"}, bus.in_ready, 1'b1);
      applyStimulus(x0, w0, b);
      checkOutput({tag, ".zvalid_mid"}, bus.z_valid, 1'b0);
      checkOutput({tag, ".ready_acc"}, bus.in_ready, 1'b1);
      applyStimulus(x1, w1, 8'h55);
      bus.in_valid = 1'b0;
      checkOutput({tag, ".zvalid"}, bus.z_valid, 1'b1);
      checkOutput({tag, ".zvalue"}, bus.z_value, exp_z);
      checkOutput({tag, ".sat"}, bus.sat, exp_sat);
      checkOutput({tag, ".ready_out"}, bus.in_ready, 1'b0);
      @(negedge clk);
      checkOutput({tag, ".zvalid_drop"}, bus.z_valid, 1'b0);
      checkOutput({tag, ".ready_back"}, bus.in_ready, 1'b1);
   endtask

   initial begin
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      bus.x_in     = '0;
      bus.w_in     = '0;
      bus.bias     = '0;
      bus.z_ready  = 1'b1;

      // Reset state.
      #2;
      checkOutput("rst.in_ready", bus.in_ready, 1'b0);
      checkOutput("rst.z_valid", bus.z_valid, 1'b0);
      checkOutput("rst.z_value", bus.z_value, 8'h00);
      checkOutput("rst.sat", bus.sat, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Basic sum: -1.0 + 1.0*2.0 + 1.0*2.0 = 3.0.
      runEval("basic", 8'h10, 8'h20, 8'h10, 8'h20, 8'hF0, 8'h30, 1'b0);
      // Positive clip.
      runEval("satpos", 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 1'b1);
      // Negative clip: (-2048 - 16256 + 16129) >>> 4 = -136.
      runEval("satneg", 8'h80, 8'h7F, 8'h7F, 8'h7F, 8'h80, 8'h80, 1'b1);
      // Floor rounding of -1/256 gives -1/16.
      runEval("floor", 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0);
      // Mixed signs: 64 + 128 - 384 = -192 -> -12.
      runEval("mixed", 8'h08, 8'h10, 8'h18, 8'hF0, 8'h04, 8'hF4, 1'b0);
      // Exactly at the range limits: no clipping reported.
      runEval("edgemax", 8'h00, 8'h00, 8'h00, 8'h00, 8'h7F, 8'h7F, 1'b0);
      runEval("edgemin", 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h80, 1'b0);

      // Backpressure: result must hold and extra beats must be ignored.
      bus.z_ready = 1'b0;
      applyStimulus(8'h10, 8'h20, 8'hF0);
      applyStimulus(8'h10, 8'h20, 8'h00);
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp.z_valid", bus.z_valid, 1'b1);
         checkOutput("bp.z_value", bus.z_value, 8'h30);
         checkOutput("bp.sat", bus.sat, 1'b0);
         checkOutput("bp.in_ready", bus.in_ready, 1'b0);
         applyStimulus(8'h7F, 8'h7F, 8'h7F);
      end
      bus.in_valid = 1'b0;
      bus.z_ready  = 1'b1;
      checkOutput("bp.z_valid_held", bus.z_valid, 1'b1);
      @(negedge clk);
      checkOutput("bp.z_valid_drop", bus.z_valid, 1'b0);
      checkOutput("bp.in_ready_back", bus.in_ready, 1'b1);
      runEval("after_bp", 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0);

      // Reset in the middle of an evaluation.
      applyStimulus(8'h7F, 8'h7F, 8'h7F);
      bus.in_valid = 1'b0;
      rst = 1'b0;
      #1;
      checkOutput("midrst.in_ready", bus.in_ready, 1'b0);
      checkOutput("midrst.z_valid", bus.z_valid, 1'b0);
      checkOutput("midrst.z_value", bus.z_value, 8'h00);
      checkOutput("midrst.sat", bus.sat, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      runEval("post_rst", 8'h10, 8'h20, 8'h10, 8'h20, 8'hF0, 8'h30, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
